// File: rtl/ins_pkg.sv
// Shared definitions for the instruction encoder: op enumeration, opcode nibbles,
// jump sub-codes, memory depth and the operand legality rule.
package ins_pkg;

    localparam int MEM_DEPTH = 256;

    typedef enum logic [3:0] {
        OP_MOVA = 4'd0,
        OP_MOVB = 4'd1,
        OP_MOVC = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_AND  = 4'd5,
        OP_NOT  = 4'd6,
        OP_RSR  = 4'd7,
        OP_RSL  = 4'd8,
        OP_JMP  = 4'd9,
        OP_JZ   = 4'd10,
        OP_JC   = 4'd11,
        OP_IN   = 4'd12,
        OP_OUT  = 4'd13,
        OP_NOP  = 4'd14,
        OP_HALT = 4'd15
    } op_e;

    localparam logic [3:0] NIB_MOV   = 4'b1100;
    localparam logic [3:0] NIB_ADD   = 4'b1001;
    localparam logic [3:0] NIB_SUB   = 4'b0110;
    localparam logic [3:0] NIB_AND   = 4'b1011;
    localparam logic [3:0] NIB_NOT   = 4'b0101;
    localparam logic [3:0] NIB_SHIFT = 4'b1010;
    localparam logic [3:0] NIB_JUMP  = 4'b0011;
    localparam logic [3:0] NIB_IN    = 4'b0010;
    localparam logic [3:0] NIB_OUT   = 4'b0100;
    localparam logic [3:0] NIB_NOP   = 4'b0111;
    localparam logic [3:0] NIB_HALT  = 4'b1000;

    localparam logic [3:0] JSUB_JMP = 4'b0000;
    localparam logic [3:0] JSUB_JZ  = 4'b0001;
    localparam logic [3:0] JSUB_JC  = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    // Register 11 is reserved by movb/movc, so these combinations would not decode back.
    function automatic logic is_illegal(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs);
        case (op_e'(op))
            OP_MOVA:                return (rd == 2'b11) || (rs == 2'b11);
            OP_ADD, OP_SUB, OP_AND: return (rd == 2'b11) && (rs == 2'b11);
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ins_encode_byte.sv
// Combinational opcode-byte encoder; flags jumps, which need a trailing target byte.
module ins_encode_byte
    import ins_pkg::*;
(
    input  logic [3:0] op,
    input  logic [1:0] rd,
    input  logic [1:0] rs,
    output logic [7:0] enc_byte,
    output logic       two_byte
);

    always_comb begin
        enc_byte = 8'h00;
        two_byte = 1'b0;
        case (op_e'(op))
            OP_MOVA: enc_byte = {NIB_MOV, rd, rs};
            OP_MOVB: enc_byte = {NIB_MOV, 2'b11, rs};
            OP_MOVC: enc_byte = {NIB_MOV, rd, 2'b11};
            OP_ADD:  enc_byte = {NIB_ADD, rd, rs};
            OP_SUB:  enc_byte = {NIB_SUB, rd, rs};
            OP_AND:  enc_byte = {NIB_AND, rd, rs};
            OP_NOT:  enc_byte = {NIB_NOT, rd, 2'b00};
            OP_RSR:  enc_byte = {NIB_SHIFT, rd, 2'b00};
            OP_RSL:  enc_byte = {NIB_SHIFT, rd, 2'b11};
            OP_JMP: begin
                enc_byte = {NIB_JUMP, JSUB_JMP};
                two_byte = 1'b1;
            end
            OP_JZ: begin
                enc_byte = {NIB_JUMP, JSUB_JZ};
                two_byte = 1'b1;
            end
            OP_JC: begin
                enc_byte = {NIB_JUMP, JSUB_JC};
                two_byte = 1'b1;
            end
            OP_IN:   enc_byte = {NIB_IN, rd, 2'b00};
            OP_OUT:  enc_byte = {NIB_OUT, 2'b00, rs};
            OP_NOP:  enc_byte = {NIB_NOP, 4'b0000};
            OP_HALT: enc_byte = {NIB_HALT, 4'b0000};
        endcase
    end

endmodule

// File: rtl/ins_encode_seq.sv
// Instruction encoder writing program bytes sequentially into a 256-byte memory.
// Define INS_ENCODE_CHECK_EN to reject illegal operand combinations with an err pulse.
module ins_encode_seq
    import ins_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] op,
    input  logic [1:0] rd,
    input  logic [1:0] rs,
    input  logic [7:0] tgt,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       full,
    output logic       err,
    output logic [8:0] count
);

    localparam logic [8:0] LAST_SLOT = 9'(MEM_DEPTH - 1);

    state_e     state;
    state_e     state_next;
    logic [7:0] ptr;
    logic [7:0] tgt_q;
    logic [7:0] enc_byte;
    logic       two_byte;
    logic       accept;
    logic       illegal;
    logic       no_room;

    ins_encode_byte u_encode (
        .op       (op),
        .rd       (rd),
        .rs       (rs),
        .enc_byte (enc_byte),
        .two_byte (two_byte)
    );

`ifdef INS_ENCODE_CHECK_EN
    assign illegal = is_illegal(op, rd, rs);
`else
    assign illegal = 1'b0;
`endif

    assign in_ready = (state == ST_IDLE);
    assign full     = (state == ST_FULL);
    assign accept   = in_valid && in_ready;
    // Only one free slot left: the 256th byte is about to be written, or a jump cannot fit.
    assign no_room  = (count == LAST_SLOT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && !illegal) begin
                    if (two_byte) begin
                        state_next = no_room ? ST_FULL : ST_ARG;
                    end else if (no_room) begin
                        state_next = ST_FULL;
                    end
                end
            end
            ST_ARG:  state_next = (ptr == 8'hFF) ? ST_FULL : ST_IDLE;
            ST_FULL: state_next = ST_FULL;
            default: state_next = ST_IDLE;
        endcase
    end

    // Write port, pointer and counters; wr_addr/wr_data hold their last values when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 8'h00;
            count   <= 9'd0;
            tgt_q   <= 8'h00;
            wr_en   <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
            err     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            err   <= 1'b0;
            if (accept) begin
                if (illegal || (two_byte && no_room)) begin
                    err <= 1'b1;
                end else begin
                    wr_en   <= 1'b1;
                    wr_addr <= ptr;
                    wr_data <= enc_byte;
                    ptr     <= ptr + 8'd1;
                    count   <= count + 9'd1;
                    if (two_byte) begin
                        tgt_q <= tgt;
                    end
                end
            end else if (state == ST_ARG) begin
                wr_en   <= 1'b1;
                wr_addr <= ptr;
                wr_data <= tgt_q;
                ptr     <= ptr + 8'd1;
                count   <= count + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_ins_encode_seq.sv
// Self-checking bench for ins_encode_seq: a byte-queue reference model compared every
// cycle, plus directed scenarios pinned with literal expectations.
module tb_ins_encode_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] tgt;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       full;
    logic       err;
    logic [8:0] count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ins_encode_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rd       (rd),
        .rs       (rs),
        .tgt      (tgt),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .full     (full),
        .err      (err),
        .count    (count)
    );

    // Model: accepted requests push their bytes into a queue that drains one byte per cycle.
    bit         model_live = 1'b0;
    int         m_count;
    bit         m_full;
    bit         m_ready_now;
    logic [7:0] m_pend[$];
    logic       e_wr_en;
    logic       e_err;
    logic [7:0] e_addr;
    logic [7:0] e_data;

    function automatic bit is_jump(input int o);
        return (o >= 9) && (o <= 11);
    endfunction

    function automatic bit ref_illegal(input int o, input int d, input int s);
`ifdef INS_ENCODE_CHECK_EN
        if (o == 0) return (d == 3) || (s == 3);
        if (o >= 3 && o <= 5) return (d == 3) && (s == 3);
        return 1'b0;
`else
        return (o < 0) && (d < 0) && (s < 0);
`endif
    endfunction

    function automatic logic [7:0] ref_encode(input int o, input int d, input int s);
        int v;
        case (o)
            0:       v = 12 * 16 + d * 4 + s;
            1:       v = 12 * 16 + 3 * 4 + s;
            2:       v = 12 * 16 + d * 4 + 3;
            3:       v = 9 * 16 + d * 4 + s;
            4:       v = 6 * 16 + d * 4 + s;
            5:       v = 11 * 16 + d * 4 + s;
            6:       v = 5 * 16 + d * 4;
            7:       v = 10 * 16 + d * 4;
            8:       v = 10 * 16 + d * 4 + 3;
            9:       v = 3 * 16 + 0;
            10:      v = 3 * 16 + 1;
            11:      v = 3 * 16 + 2;
            12:      v = 2 * 16 + d * 4;
            13:      v = 4 * 16 + s;
            14:      v = 7 * 16;
            default: v = 8 * 16;
        endcase
        return 8'(v);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_live = 1'b1;
            m_count    = 0;
            m_full     = 1'b0;
            m_pend.delete();
            e_wr_en    = 1'b0;
            e_err      = 1'b0;
            e_addr     = 8'h00;
            e_data     = 8'h00;
        end else if (model_live) begin
            m_ready_now = (m_pend.size() == 0) && !m_full;
            e_wr_en     = 1'b0;
            e_err       = 1'b0;
            if (in_valid && m_ready_now) begin
                if (ref_illegal(int'(op), int'(rd), int'(rs))) begin
                    e_err = 1'b1;
                end else if (is_jump(int'(op)) && (256 - m_count) < 2) begin
                    e_err  = 1'b1;
                    m_full = 1'b1;
                end else begin
                    m_pend.push_back(ref_encode(int'(op), int'(rd), int'(rs)));
                    if (is_jump(int'(op))) m_pend.push_back(tgt);
                end
            end
            if (m_pend.size() > 0) begin
                e_data  = m_pend.pop_front();
                e_wr_en = 1'b1;
                e_addr  = 8'(m_count % 256);
                m_count = m_count + 1;
                if (m_count == 256) m_full = 1'b1;
            end
        end
    end

    task automatic check_output(input string name, input logic [15:0] act,
                                input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            check_output("model wr_en",    16'(wr_en),    16'(e_wr_en));
            check_output("model wr_addr",  16'(wr_addr),  16'(e_addr));
            check_output("model wr_data",  16'(wr_data),  16'(e_data));
            check_output("model err",      16'(err),      16'(e_err));
            check_output("model count",    16'(count),    16'(m_count));
            check_output("model full",     16'(full),     16'(m_full));
            check_output("model in_ready", 16'(in_ready),
                         16'((m_pend.size() == 0) && !m_full));
        end
    end

    task automatic apply_stimulus(input bit v, input int o, input int d, input int s,
                                  input int t);
        in_valid = v;
        op       = 4'(o);
        rd       = 2'(d);
        rs       = 2'(s);
        tgt      = 8'(t);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 4'd0;
        rd       = 2'd0;
        rs       = 2'd0;
        tgt      = 8'd0;
        repeat (2) @(negedge clk);
        check_output("reset wr_en",   16'(wr_en),   16'h0);
        check_output("reset wr_addr", 16'(wr_addr), 16'h00);
        check_output("reset wr_data", 16'(wr_data), 16'h00);
        check_output("reset count",   16'(count),   16'd0);
        check_output("reset full",    16'(full),    16'h0);
        check_output("reset err",     16'(err),     16'h0);
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("release in_ready", 16'(in_ready), 16'h1);

        apply_stimulus(1, 3, 1, 2, 0);
        check_output("add wr_en",   16'(wr_en),   16'h1);
        check_output("add wr_addr", 16'(wr_addr), 16'h00);
        check_output("add wr_data", 16'(wr_data), 16'h96);
        check_output("add count",   16'(count),   16'd1);

        repeat (15) apply_stimulus(1, 14, 0, 0, 0);
        apply_stimulus(1, 10, 0, 0, 'h5A);
        check_output("jz op addr",  16'(wr_addr),  16'h10);
        check_output("jz op data",  16'(wr_data),  16'h31);
        check_output("jz in_ready", 16'(in_ready), 16'h0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("jz tgt addr",     16'(wr_addr),  16'h11);
        check_output("jz tgt data",     16'(wr_data),  16'h5A);
        check_output("jz tgt wr_en",    16'(wr_en),    16'h1);
        check_output("jz after ready",  16'(in_ready), 16'h1);

        apply_stimulus(1, 14, 0, 0, 0);
        check_output("nop addr", 16'(wr_addr), 16'h12);
        check_output("nop data", 16'(wr_data), 16'h70);
        apply_stimulus(1, 15, 0, 0, 0);
        check_output("halt addr", 16'(wr_addr), 16'h13);
        check_output("halt data", 16'(wr_data), 16'h80);
        apply_stimulus(1, 1, 0, 1, 0);
        check_output("movb addr",  16'(wr_addr), 16'h14);
        check_output("movb data",  16'(wr_data), 16'hCD);
        check_output("movb wr_en", 16'(wr_en),   16'h1);

        apply_stimulus(1, 0, 3, 0, 0);
`ifdef INS_ENCODE_CHECK_EN
        check_output("illegal mova err",   16'(err),   16'h1);
        check_output("illegal mova wr_en", 16'(wr_en), 16'h0);
`else
        check_output("raw mova data",  16'(wr_data), 16'hCC);
        check_output("raw mova wr_en", 16'(wr_en),   16'h1);
        check_output("raw mova err",   16'(err),     16'h0);
`endif
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("idle err", 16'(err), 16'h0);

        apply_stimulus(1, 9, 0, 0, 'hA5);
        check_output("jmp op data", 16'(wr_data), 16'h30);
        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("arg reset wr_en", 16'(wr_en), 16'h0);
        check_output("arg reset count", 16'(count), 16'd0);
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("arg reset in_ready", 16'(in_ready), 16'h1);
        check_output("arg reset no tgt",   16'(wr_en),    16'h0);

        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            apply_stimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 255)));
        end
        rst = 1'b0;

        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (256) apply_stimulus(1, 14, 0, 0, 0);
        check_output("fill last addr", 16'(wr_addr),  16'hFF);
        check_output("fill count",     16'(count),    16'h100);
        check_output("fill full",      16'(full),     16'h1);
        check_output("fill in_ready",  16'(in_ready), 16'h0);
        apply_stimulus(1, 14, 0, 0, 0);
        check_output("full no write",  16'(wr_en),    16'h0);
        check_output("full count",     16'(count),    16'h100);

        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (255) apply_stimulus(1, 14, 0, 0, 0);
        apply_stimulus(1, 9, 0, 0, 'h44);
        check_output("jmp at 255 err",   16'(err),   16'h1);
        check_output("jmp at 255 wr_en", 16'(wr_en), 16'h0);
        check_output("jmp at 255 count", 16'(count), 16'h0FF);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("jmp at 255 no tgt", 16'(wr_en), 16'h0);
        check_output("jmp at 255 err end", 16'(err),  16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ins_encode_seq.md
INS_ENCODE_SEQ -- requirements
Module: ins_encode_seq

Interface
REQ-001 SHALL have exactly one clock: clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have in_valid, input, 1, the instruction request is valid.
REQ-004 SHALL have in_ready, output, 1, the block accepts a request this cycle.
REQ-005 SHALL have op, input, 4, operation select: 0 mova, 1 movb, 2 movc, 3 add, 4 sub, 5 and, 6 not, 7 rsr, 8 rsl, 9 jmp, 10 jz, 11 jc, 12 in, 13 out, 14 nop, 15 halt.
REQ-006 SHALL have rd and rs, input, 2 each, destination and source register fields.
REQ-007 SHALL have tgt, input, 8, jump target byte, used only by jmp, jz and jc.
REQ-008 SHALL have wr_en, output, 1, program-memory write strobe.
REQ-009 SHALL have wr_addr, output, 8, program-memory write address.
REQ-010 SHALL have wr_data, output, 8, encoded instruction byte.
REQ-011 SHALL have full, output, 1, program memory is exhausted.
REQ-012 SHALL have err, output, 1, one-cycle pulse flagging a rejected or illegal request.
REQ-013 SHALL have count, output, 9, number of bytes written since reset.

Function
REQ-014 A request is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-015 Byte encoding (high nibble, low nibble):
- mova: 1100, rd, rs
- movb: 1100, 11, rs
- movc: 1100, rd, 11
- add: 1001, rd, rs
- sub: 0110, rd, rs
- and: 1011, rd, rs
- not: 0101, rd, 00
- rsr: 1010, rd, 00
- rsl: 1010, rd, 11
- jmp: 0011, 0000
- jz: 0011, 0001
- jc: 0011, 0010
- in: 0010, rd, 00
- out: 0100, 00, rs
- nop: 0111, 0000
- halt: 1000, 0000
REQ-016 Every byte produced SHALL decode back to exactly the requested operation.
REQ-017 wr_en, wr_addr and wr_data SHALL be registered; the opcode byte appears in the cycle after acceptance, at wr_addr = ptr, and ptr then increments.
REQ-018 FSM states and transitions:
- IDLE: in_ready = 1.
- ARG: in_ready = 0; tgt is captured at acceptance; in the cycle after the opcode byte, tgt is written at ptr + 1.
- FULL: in_ready = 0.
- Transitions: IDLE->ARG on an accepted jump; ARG->IDLE, or ARG->FULL if ptr wraps to 0.
REQ-019 Single-byte operations SHALL sustain one accept per cycle; jumps SHALL take two cycles.
REQ-020 full SHALL rise when count reaches 256; the state then moves to FULL. ptr wraps to 0 but no further writes occur.
REQ-021 A jump accepted with only one free slot (count = 255) SHALL write nothing, pulse err, and enter FULL.
REQ-022 wr_en SHALL be 0 in every cycle without a byte to write; wr_addr and wr_data then hold their last values.

Reset
REQ-023 While rst = 1, regardless of state (including mid-ARG), the following SHALL hold on the next edge:
- state = IDLE, ptr = 0, count = 0
- wr_en = 0, wr_addr = 0x00, wr_data = 0x00
- full = 0, err = 0, in_ready = 1 after release
REQ-024 A partially emitted jump SHALL be abandoned on reset without writing its target byte.

Configuration
REQ-025 Macro INS_ENCODE_CHECK_EN enables operand legality checking.
REQ-026 With INS_ENCODE_CHECK_EN defined, illegal requests SHALL be accepted, pulse err, and write nothing. Illegal means:
- mova with rd = 11 or rs = 11
- add, sub or and with rd = 11 and rs = 11
REQ-027 Without INS_ENCODE_CHECK_EN, such requests SHALL be encoded raw per REQ-015, and err SHALL pulse only per REQ-021.

Structure
REQ-028 Shared package ins_pkg SHALL hold:
- the 4-bit op enumeration
- the 4-bit opcode-nibble constants
- the jump sub-codes
- the constant MEM_DEPTH = 256
REQ-029 The combinational byte encoding SHALL sit in sub-module ins_encode_byte (inputs op, rd, rs; outputs byte and two_byte); the FSM, pointer and counters stay in ins_encode_seq.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset, then accept add rd=01 rs=10 -> next cycle wr_en = 1, wr_addr = 0x00, wr_data = 0x96, count = 1.
- Accept jz with tgt = 0x5A at ptr = 0x10 -> wr 0x31 at 0x10, then 0x5A at 0x11; in_ready = 0 for exactly one cycle.
- Back-to-back nop, halt, movb rs=01 -> data 0x70, 0x80, 0xCD at consecutive addresses on three consecutive cycles.
- Fill with 256 nops -> full = 1 after the last write, in_ready = 0, no further wr_en; with count = 255, a jmp -> err pulse and no write.
- With INS_ENCODE_CHECK_EN, mova rd=11 rs=00 -> err = 1 and no write; without the macro -> wr_data = 0xCC.
- Assert rst during ARG -> the target byte is not written, and wr_en = 0, count = 0, in_ready = 1 afterwards.
